// File: rtl/counter_monitor.sv
// counter_monitor
//   Passive checker that sits beside a loadable up counter. Every clock it
//   predicts the counter's next value from the sampled load interface and
//   count output, then compares the following sample against that
//   prediction. It also keeps saturating statistics on loads, wraps and
//   mismatches.
//
// Ports
//   clk_i         rising-edge clock shared with the observed counter
//   rst_ni        asynchronous active-low monitor reset
//   dut_rst_i     observed counter's active-high reset; suspends checking
//   ld_i          observed counter's load strobe
//   ldvalue_i     observed counter's load value
//   dout_i        observed counter's output
//   clr_stats_i   synchronous clear of the statistics and err_sticky_o
//   locked_o      high while an expectation is held and checking is active
//   err_o         one-cycle pulse per detected mismatch
//   err_sticky_o  set by any mismatch until reset or clr_stats_i
//   err_count_o   saturating mismatch count
//   load_count_o  saturating count of sampled loads
//   wrap_count_o  saturating count of predicted all-ones-to-zero wraps
module counter_monitor #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned STATW = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             dut_rst_i,
   input  logic             ld_i,
   input  logic [WIDTH-1:0] ldvalue_i,
   input  logic [WIDTH-1:0] dout_i,
   input  logic             clr_stats_i,
   output logic             locked_o,
   output logic             err_o,
   output logic             err_sticky_o,
   output logic [STATW-1:0] err_count_o,
   output logic [STATW-1:0] load_count_o,
   output logic [STATW-1:0] wrap_count_o
);

   typedef enum logic {
      UNSYNC = 1'b0,
      TRACK  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] pred;
   logic             mismatch;
   logic             err_q, err_d;
   logic             sticky_q, sticky_d;
   logic [STATW-1:0] errc_q, errc_d;
   logic [STATW-1:0] ldc_q, ldc_d;
   logic [STATW-1:0] wrc_q, wrc_d;
   logic             ld_ev, wrap_ev;

   function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v,
                                                 input logic             en);
      return (en && (v != '1)) ? v + STATW'(1) : v;
   endfunction

   // Prediction always uses the actually sampled dout, so a single glitch
   // produces exactly one error instead of a cascade.
   always_comb begin
      pred    = ld_i ? ldvalue_i : dout_i + WIDTH'(1);
      ld_ev   = ld_i & ~dut_rst_i;
      wrap_ev = ~ld_i & ~dut_rst_i & (dout_i == '1);
   end

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      mismatch = 1'b0;
      case (state_q)
         UNSYNC: begin
            if (!dut_rst_i) begin
               exp_d   = pred;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (dut_rst_i) begin
               state_d = UNSYNC;
            end else begin
               mismatch = (dout_i != exp_q);
               exp_d    = pred;
            end
         end
         default: state_d = UNSYNC;
      endcase
      err_d = mismatch;
   end

   // Clear takes priority over any same-edge increment or sticky set.
   always_comb begin
      sticky_d = sticky_q | mismatch;
      errc_d   = sat_inc(errc_q, mismatch);
      ldc_d    = sat_inc(ldc_q, ld_ev);
      wrc_d    = sat_inc(wrc_q, wrap_ev);
      if (clr_stats_i) begin
         sticky_d = 1'b0;
         errc_d   = '0;
         ldc_d    = '0;
         wrc_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= UNSYNC;
         exp_q    <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         errc_q   <= '0;
         ldc_q    <= '0;
         wrc_q    <= '0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         errc_q   <= errc_d;
         ldc_q    <= ldc_d;
         wrc_q    <= wrc_d;
      end
   end

   assign locked_o     = (state_q == TRACK);
   assign err_o        = err_q;
   assign err_sticky_o = sticky_q;
   assign err_count_o  = errc_q;
   assign load_count_o = ldc_q;
   assign wrap_count_o = wrc_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor. The stimulus process plays the role
// of the observed counter and pushes hand-computed expectations into a
// scoreboard queue; a monitor process pops and compares them after each
// clock edge, or immediately when an asynchronous check is signalled.
module tb_counter_monitor;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       dut_rst_i;
   logic       ld_i;
   logic [3:0] ldvalue_i;
   logic [3:0] dout_i;
   logic       clr_stats_i;
   logic       locked_o;
   logic       err_o;
   logic       err_sticky_o;
   logic [7:0] err_count_o;
   logic [7:0] load_count_o;
   logic [7:0] wrap_count_o;

   counter_monitor #(.WIDTH(4), .STATW(8)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .dut_rst_i    (dut_rst_i),
      .ld_i         (ld_i),
      .ldvalue_i    (ldvalue_i),
      .dout_i       (dout_i),
      .clr_stats_i  (clr_stats_i),
      .locked_o     (locked_o),
      .err_o        (err_o),
      .err_sticky_o (err_sticky_o),
      .err_count_o  (err_count_o),
      .load_count_o (load_count_o),
      .wrap_count_o (wrap_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int         due;
      string      nm;
      logic       lk;
      logic       er;
      logic       st;
      logic [7:0] ec;
      logic [7:0] lc;
      logic [7:0] wc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   fails  = 0;
   event async_ev;

   // Monitor: counts edges and compares every expectation that is due.
   initial begin
      forever begin
         @(posedge clk_i or async_ev);
         if (clk_i) cyc++;
         #1;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (locked_o !== e.lk || err_o !== e.er || err_sticky_o !== e.st ||
                err_count_o !== e.ec || load_count_o !== e.lc ||
                wrap_count_o !== e.wc) begin
               fails++;
               $display("FAIL %s @edge %0d: got lk=%b err=%b st=%b ec=%0d lc=%0d wc=%0d, want lk=%b err=%b st=%b ec=%0d lc=%0d wc=%0d",
                        e.nm, cyc, locked_o, err_o, err_sticky_o, err_count_o,
                        load_count_o, wrap_count_o, e.lk, e.er, e.st, e.ec,
                        e.lc, e.wc);
            end
         end
      end
   end

   task automatic push(input int due, input string nm, input logic lk,
                       input logic er, input logic st, input int ec,
                       input int lc, input int wc);
      exp_t e;
      e.due = due; e.nm = nm; e.lk = lk; e.er = er; e.st = st;
      e.ec = 8'(ec); e.lc = 8'(lc); e.wc = 8'(wc);
      sb.push_back(e);
   endtask

   // Drive one cycle of counter activity and queue the state expected
   // right after the coming edge.
   task automatic step(input string nm, input logic ld, input logic [3:0] lv,
                       input logic [3:0] d, input logic dr, input logic clr,
                       input logic lk, input logic er, input logic st,
                       input int ec, input int lc, input int wc);
      @(negedge clk_i);
      ld_i = ld; ldvalue_i = lv; dout_i = d; dut_rst_i = dr; clr_stats_i = clr;
      push(cyc + 1, nm, lk, er, st, ec, lc, wc);
   endtask

   task automatic async_check(input string nm);
      push(cyc, nm, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      -> async_ev;
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, pending=%0d required=0", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int ec;
      logic [3:0] seq[10];
      seq = '{4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

      // Reset held with busy inputs: everything stays zero.
      rst_ni = 1'b0; dut_rst_i = 1'b0; ld_i = 1'b1; ldvalue_i = 4'h5;
      dout_i = 4'hF; clr_stats_i = 1'b0;
      #2;
      async_check("reset_now");
      for (int i = 0; i < 3; i++)
         step("reset_hold", 1'b1, 4'h5, 4'hF, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);

      // Release monitor reset; observed counter held in reset for 5 edges.
      @(negedge clk_i);
      rst_ni = 1'b1;
      ld_i = 1'b0; ldvalue_i = 4'h0; dout_i = 4'h0; dut_rst_i = 1'b1;
      push(cyc + 1, "dut_rst", 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 5; i++)
         step("dut_rst", 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

      // Free run 0x0..0xF,0x0..0x3: one wrap once 0xF is sampled.
      for (int i = 0; i < 20; i++)
         step("free_run", 1'b0, 4'h0, 4'(i), 1'b0, 1'b0, 1, 0, 0, 0, 0,
              (i >= 15) ? 1 : 0);

      // Load 0xA while counting, then 0xA, 0xB, 0xC.
      step("load", 1'b1, 4'hA, 4'h4, 1'b0, 1'b0, 1, 0, 0, 0, 1, 1);
      step("after_load", 1'b0, 4'h0, 4'hA, 1'b0, 1'b0, 1, 0, 0, 0, 1, 1);
      step("after_load", 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 1, 0, 0, 0, 1, 1);
      step("after_load", 1'b0, 4'h0, 4'hC, 1'b0, 1'b0, 1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 10; i++)
         step("run2", 1'b0, 4'h0, seq[i], 1'b0, 1'b0, 1, 0, 0, 0, 1,
              (i >= 2) ? 2 : 1);

      // Glitch: 0x3 where 0x7 is expected, then 0x4, 0x5.
      step("fault", 1'b0, 4'h0, 4'h3, 1'b0, 1'b0, 1, 1, 1, 1, 1, 2);
      step("post_fault", 1'b0, 4'h0, 4'h4, 1'b0, 1'b0, 1, 0, 1, 1, 1, 2);
      step("post_fault", 1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 1, 0, 1, 1, 1, 2);

      // Stuck at 0: every edge mismatches; count saturates at 255.
      for (int n = 1; n <= 300; n++) begin
         ec = (n + 1 > 255) ? 255 : n + 1;
         step("saturate", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1, 1, 1, ec, 1, 2);
      end

      // Clear on the same edge as a mismatch: stats clear, err still pulses.
      step("clr_stats", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1, 1, 0, 0, 0, 0);
      step("post_clr", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1, 1, 1, 1, 0, 0);
      step("post_clr", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1, 1, 1, 2, 0, 0);

      // Asynchronous reset between edges.
      @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      async_check("midop_reset");
      step("midop_hold", 1'b0, 4'h0, 4'h7, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);

      // Release: first edge relocks with no error reported.
      @(negedge clk_i);
      rst_ni = 1'b1;
      ld_i = 1'b0; ldvalue_i = 4'h0; dout_i = 4'h1; dut_rst_i = 1'b0;
      push(cyc + 1, "relock", 1, 0, 0, 0, 0, 0);
      step("relock_run", 1'b0, 4'h0, 4'h2, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0);

      // Back-to-back loads: expectation follows the latest ldvalue.
      step("ld_b2b", 1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 1, 0, 0, 0, 1, 0);
      step("ld_b2b", 1'b1, 4'h7, 4'h2, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0);
      step("ld_b2b_chk", 1'b0, 4'h0, 4'h7, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0);

      // Observed counter reset while tracking: unlock, no compare.
      step("trk_dut_rst", 1'b0, 4'h0, 4'h9, 1'b1, 1'b0, 0, 0, 0, 0, 2, 0);
      step("resync", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0);
      step("resync_run", 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0);

      // Load then mismatch against the loaded value.
      step("ld_then_bad", 1'b1, 4'hC, 4'h2, 1'b0, 1'b0, 1, 0, 0, 0, 3, 0);
      step("ld_then_bad", 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 1, 1, 1, 1, 3, 0);
      step("ld_then_bad", 1'b0, 4'h0, 4'hC, 1'b0, 1'b0, 1, 0, 1, 1, 3, 0);

      repeat (3) @(negedge clk_i);
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
